// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetch controller.
package prefetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  // Queue entry at the default widths (28-bit byte address, 32-bit instruction).
  // Parameterised builds supply their own entry type to the queue.
  typedef struct packed {
    logic [27:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch queue: synchronous write, flush to empty, head read straight from registers.
module prefetch_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = prefetch_pkg::entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   wr_en,
  input  entry_t wr_data,
  input  logic   rd_en,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/instr_prefetch_ctrl.sv
// Instruction prefetch controller: streams sequential words from a combinational
// instruction memory into a small queue feeding decode; redirects flush and retarget.
// Optional build macro PREFETCH_PERF_EN adds saturating perf_issued/perf_flushes counters.
module instr_prefetch_ctrl
  import prefetch_pkg::*;
#(
  parameter int unsigned        A_WIDTH  = 28,
  parameter int unsigned        D_WIDTH  = 8,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [A_WIDTH-1:0]   redirect_pc,
  output logic [A_WIDTH-1:0]   mem_addr,
  input  logic [4*D_WIDTH-1:0] mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*D_WIDTH-1:0] out_instr,
  output logic [A_WIDTH-1:0]   out_pc
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_flushes
`endif
);

  typedef struct packed {
    logic [A_WIDTH-1:0]   pc;
    logic [4*D_WIDTH-1:0] instr;
  } fetch_entry_t;

  state_t             state;
  state_t             next_state;
  logic [A_WIDTH-1:0] fpc;
  logic               enq;
  logic               deq;
  logic               q_empty;
  logic               q_full;
  fetch_entry_t       wr_entry;
  fetch_entry_t       head;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and the enqueue/dequeue decisions for this cycle.
  always_comb begin
    next_state = state;
    deq        = out_valid && out_ready;
    enq        = 1'b0;
    case (state)
      IDLE:    if (fetch_en) next_state = FETCH;
      FETCH:   begin
        if (!fetch_en) next_state = IDLE;
        enq = fetch_en && !redirect_valid && (!q_full || deq);
      end
      default: next_state = IDLE;
    endcase
  end

  // Fetch pointer: redirect wins over sequential advance; wraps modulo 2**A_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc <= {redirect_pc[A_WIDTH-1:2], 2'b00};
    end else if (enq) begin
      fpc <= fpc + A_WIDTH'(INSTR_BYTES);
    end
  end

  assign mem_addr       = fpc;
  assign wr_entry.pc    = fpc;
  assign wr_entry.instr = mem_rdata;

  // A dequeue coinciding with a redirect still advances nothing: the flush wins.
  prefetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .wr_en   (enq),
    .wr_data (wr_entry),
    .rd_en   (deq),
    .head    (head),
    .empty   (q_empty),
    .full    (q_full)
  );

  assign out_valid = !q_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

`ifdef PREFETCH_PERF_EN
  // Saturating event counters for issued instructions and redirect flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued  <= '0;
      perf_flushes <= '0;
    end else begin
      if (deq && (perf_issued != '1)) perf_issued <= perf_issued + 1'b1;
      if (redirect_valid && (perf_flushes != '1)) perf_flushes <= perf_flushes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_ctrl.sv
// Directed bench for instr_prefetch_ctrl: one DUT at RESET_PC=0, one at 2**28-4
// sharing the same control inputs, each with its own combinational memory model.
module tb_instr_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [27:0] redirect_pc = '0;
  logic        out_ready = 1'b0;

  logic [27:0] mem_addr,  w_mem_addr;
  logic [31:0] mem_rdata, w_mem_rdata;
  logic        out_valid, w_out_valid;
  logic [31:0] out_instr, w_out_instr;
  logic [27:0] out_pc,    w_out_pc;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_issued, perf_flushes, w_perf_issued, w_perf_flushes;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [27:0] a);
    if (a < 28'hC) return 32'h0000_0013;
    return 32'hA500_0000 ^ {4'h0, a};
  endfunction

  always_comb mem_rdata   = memf(mem_addr);
  always_comb w_mem_rdata = memf(w_mem_addr);

  instr_prefetch_ctrl #(
    .A_WIDTH(28), .D_WIDTH(8), .DEPTH(4), .RESET_PC(28'h0)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef PREFETCH_PERF_EN
    , .perf_issued(perf_issued), .perf_flushes(perf_flushes)
`endif
  );

  instr_prefetch_ctrl #(
    .A_WIDTH(28), .D_WIDTH(8), .DEPTH(4), .RESET_PC(28'hFFFFFFC)
  ) dut_w (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc)
`ifdef PREFETCH_PERF_EN
    , .perf_issued(w_perf_issued), .perf_flushes(w_perf_flushes)
`endif
  );

  task automatic restart(input logic fe, input logic rdy);
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; fetch_en = fe; out_ready = rdy;
  endtask

  task automatic test_reset();
    #12;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    nvec++; if (out_pc !== 28'h0) begin nerr++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    nvec++; if (out_instr !== 32'h0) begin nerr++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    nvec++; if (w_mem_addr !== 28'hFFFFFFC) begin nerr++; $display("FAIL reset_wrap_addr got=%h exp=FFFFFFC", w_mem_addr); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL stream_idle_valid got=%0b exp=0", out_valid); end
    @(negedge clk);
    nvec++; if (out_valid !== 1'b1 || out_pc !== 28'h0 || out_instr !== 32'h13) begin
      nerr++; $display("FAIL stream_pc0 got v=%0b pc=%h i=%h exp v=1 pc=0 i=13", out_valid, out_pc, out_instr); end
    nvec++; if (w_out_pc !== 28'hFFFFFFC) begin nerr++; $display("FAIL wrap_pc0 got=%h exp=FFFFFFC", w_out_pc); end
    @(negedge clk);
    nvec++; if (out_pc !== 28'h4 || out_instr !== 32'h13) begin nerr++; $display("FAIL stream_pc4 got pc=%h i=%h exp pc=4 i=13", out_pc, out_instr); end
    nvec++; if (w_out_pc !== 28'h0 || w_out_instr !== 32'h13) begin nerr++; $display("FAIL wrap_pc1 got pc=%h i=%h exp pc=0 i=13", w_out_pc, w_out_instr); end
    @(negedge clk);
    nvec++; if (out_pc !== 28'h8 || out_instr !== 32'h13) begin nerr++; $display("FAIL stream_pc8 got pc=%h i=%h exp pc=8 i=13", out_pc, out_instr); end
    nvec++; if (w_out_pc !== 28'h4) begin nerr++; $display("FAIL wrap_pc2 got=%h exp=4", w_out_pc); end
  endtask

  task automatic test_full_and_redirect();
    restart(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    nvec++; if (out_valid !== 1'b1 || out_pc !== 28'h0 || mem_addr !== 28'h10) begin
      nerr++; $display("FAIL full_hold got v=%0b pc=%h addr=%h exp v=1 pc=0 addr=10", out_valid, out_pc, mem_addr); end
    out_ready = 1'b1;
    @(negedge clk);
    nvec++; if (out_pc !== 28'h4 || mem_addr !== 28'h14) begin
      nerr++; $display("FAIL full_enq_deq got pc=%h addr=%h exp pc=4 addr=14", out_pc, mem_addr); end
    out_ready = 1'b0;
    @(negedge clk);
    nvec++; if (out_pc !== 28'h4 || mem_addr !== 28'h14) begin
      nerr++; $display("FAIL full_count_kept got pc=%h addr=%h exp pc=4 addr=14", out_pc, mem_addr); end
    redirect_valid = 1'b1; redirect_pc = 28'h103; out_ready = 1'b1;
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0 || mem_addr !== 28'h100) begin
      nerr++; $display("FAIL redirect_flush got v=%0b addr=%h exp v=0 addr=100", out_valid, mem_addr); end
    redirect_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    nvec++; if (out_valid !== 1'b1 || out_pc !== 28'h100 || out_instr !== 32'hA5000100) begin
      nerr++; $display("FAIL redirect_target got v=%0b pc=%h i=%h exp v=1 pc=100 i=a5000100", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_drain();
    restart(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    nvec++; if (mem_addr !== 28'h10 || out_pc !== 28'h0) begin
      nerr++; $display("FAIL drain_fill got addr=%h pc=%h exp addr=10 pc=0", mem_addr, out_pc); end
    fetch_en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    nvec++; if (out_pc !== 28'h4) begin nerr++; $display("FAIL drain_pc4 got=%h exp=4", out_pc); end
    @(negedge clk);
    nvec++; if (out_pc !== 28'h8) begin nerr++; $display("FAIL drain_pc8 got=%h exp=8", out_pc); end
    @(negedge clk);
    nvec++; if (out_pc !== 28'hC || out_valid !== 1'b1) begin nerr++; $display("FAIL drain_pcC got pc=%h v=%0b exp pc=c v=1", out_pc, out_valid); end
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0 || mem_addr !== 28'h10) begin
      nerr++; $display("FAIL drain_empty got v=%0b addr=%h exp v=0 addr=10", out_valid, mem_addr); end
  endtask

  task automatic test_async_reset();
    restart(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    nvec++; if (out_valid !== 1'b1 || mem_addr !== 28'hC) begin
      nerr++; $display("FAIL arst_pre got v=%0b addr=%h exp v=1 addr=c", out_valid, mem_addr); end
    #2 rst = 1'b1;
    #1;
    nvec++; if (out_valid !== 1'b0 || out_pc !== 28'h0 || out_instr !== 32'h0) begin
      nerr++; $display("FAIL arst_now got v=%0b pc=%h i=%h exp v=0 pc=0 i=0", out_valid, out_pc, out_instr); end
    nvec++; if (w_mem_addr !== 28'hFFFFFFC) begin nerr++; $display("FAIL arst_wrap_addr got=%h exp=FFFFFFC", w_mem_addr); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    nvec++; if (out_valid !== 1'b1 || out_pc !== 28'h0) begin
      nerr++; $display("FAIL arst_first got v=%0b pc=%h exp v=1 pc=0", out_valid, out_pc); end
    nvec++; if (w_out_pc !== 28'hFFFFFFC) begin nerr++; $display("FAIL arst_wrap_first got=%h exp=FFFFFFC", w_out_pc); end
  endtask

`ifdef PREFETCH_PERF_EN
  task automatic test_perf();
    restart(1'b1, 1'b1);
    nvec++; if (perf_issued !== 32'd0 || perf_flushes !== 32'd0) begin
      nerr++; $display("FAIL perf_reset got i=%0d f=%0d exp 0 0", perf_issued, perf_flushes); end
    repeat (7) @(negedge clk);
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 28'h40;
    @(negedge clk); redirect_valid = 1'b0;
    @(negedge clk); redirect_valid = 1'b1;
    @(negedge clk); redirect_valid = 1'b0;
    @(negedge clk);
    nvec++; if (perf_issued !== 32'd5 || perf_flushes !== 32'd2) begin
      nerr++; $display("FAIL perf_counts got i=%0d f=%0d exp 5 2", perf_issued, perf_flushes); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_full_and_redirect();
    test_drain();
    test_async_reset();
`ifdef PREFETCH_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
